// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared encodings for the multiply/divide sequencer
package mdu_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } mdu_state_t;

    localparam logic [1:0] ALU_AND = 2'b00;
    localparam logic [1:0] ALU_OR  = 2'b01;
    localparam logic [1:0] ALU_ADD = 2'b10;
    localparam logic [1:0] ALU_SLT = 2'b11;

    localparam logic OP_MULU = 1'b0;
    localparam logic OP_DIVU = 1'b1;

    localparam int ITER = 16;

    // Carry into each bit position given per-bit generate/propagate and carry-in.
    function automatic logic [15:0] carry_chain(input logic [15:0] gi,
                                                input logic [15:0] pi,
                                                input logic        c0);
        logic [15:0] c;
        c[0] = c0;
        for (int i = 1; i < 16; i++) begin
            c[i] = gi[i-1] | (pi[i-1] & c[i-1]);
        end
        return c;
    endfunction

endpackage

// File: rtl/alu16bit.sv
// rtl/alu16bit.sv - 16-bit carry-lookahead ALU with group generate/propagate outputs
module alu16bit
    import mdu_pkg::*;
(
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        a_invert,
    input  logic        b_invert,
    input  logic        cin,
    input  logic        less,
    input  logic [1:0]  operation,
    output logic [15:0] result,
    output logic        g,
    output logic        p
);

    logic [15:0] aa;
    logic [15:0] bb;
    logic [15:0] gi;
    logic [15:0] pi;
    logic [15:0] c_sum;
    logic [15:0] c_grp;

    always_comb begin
        aa    = a_invert ? ~a : a;
        bb    = b_invert ? ~b : b;
        gi    = aa & bb;
        pi    = aa | bb;
        c_sum = carry_chain(gi, pi, cin);
        // Group terms exclude cin so the caller can form cout = g | (p & cin).
        c_grp = carry_chain(gi, pi, 1'b0);
        g     = gi[15] | (pi[15] & c_grp[15]);
        p     = &pi;
        case (operation)
            ALU_AND: result = aa & bb;
            ALU_OR:  result = aa | bb;
            ALU_ADD: result = aa ^ bb ^ c_sum;
            default: result = {15'd0, less};
        endcase
    end

endmodule

// File: rtl/mdu_seq_ctrl.sv
// rtl/mdu_seq_ctrl.sv - iterative 16x16 unsigned multiply / divide sequencer
module mdu_seq_ctrl
    import mdu_pkg::*;
#(
    parameter int               WIDTH    = 16,
    parameter logic [WIDTH-1:0] DBZ_QUOT = 16'hFFFF
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    output logic             dbz_o
);

    mdu_state_t state;
    logic [3:0]  cnt;
    logic        op;
    logic [15:0] h;
    logic [15:0] l;
    logic [15:0] m;

    logic [15:0] rs;
    logic [15:0] alu_a;
    logic [15:0] alu_y;
    logic        alu_cin;
    logic        alu_g;
    logic        alu_p;
    logic        cout;
    logic [15:0] h_nxt;
    logic [15:0] l_nxt;

    assign rs      = {h[14:0], l[15]};
    assign alu_a   = (op == OP_DIVU) ? rs : h;
    assign alu_cin = (op == OP_DIVU);
    assign cout    = alu_g | (alu_p & alu_cin);

    alu16bit u_alu (
        .a         (alu_a),
        .b         (m),
        .a_invert  (1'b0),
        .b_invert  (alu_cin),
        .cin       (alu_cin),
        .less      (1'b0),
        .operation (ALU_ADD),
        .result    (alu_y),
        .g         (alu_g),
        .p         (alu_p)
    );

    // Shift-add for multiply, restoring shift-subtract for divide; h[15] is the 17th remainder bit.
    always_comb begin
        h_nxt = h;
        l_nxt = l;
        if (op == OP_MULU) begin
            if (l[0]) begin
                h_nxt = {cout, alu_y[15:1]};
                l_nxt = {alu_y[0], l[15:1]};
            end else begin
                h_nxt = {1'b0, h[15:1]};
                l_nxt = {h[0], l[15:1]};
            end
        end else begin
            if (h[15] | cout) begin
                h_nxt = alu_y;
                l_nxt = {l[14:0], 1'b1};
            end else begin
                h_nxt = rs;
                l_nxt = {l[14:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state  <= S_IDLE;
            cnt    <= 4'd0;
            op     <= OP_MULU;
            h      <= 16'd0;
            l      <= 16'd0;
            m      <= 16'd0;
            busy_o <= 1'b0;
            done_o <= 1'b0;
            hi_o   <= '0;
            lo_o   <= '0;
            dbz_o  <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        op     <= op_i;
                        cnt    <= 4'd0;
                        h      <= 16'd0;
                        busy_o <= 1'b1;
                        if (op_i == OP_DIVU) begin
                            l <= a_i;
                            m <= b_i;
                        end else begin
                            l <= b_i;
                            m <= a_i;
                        end
                        if (op_i == OP_DIVU && b_i == '0) begin
                            state  <= S_DONE;
                            h      <= a_i;
                            l      <= DBZ_QUOT;
                            hi_o   <= a_i;
                            lo_o   <= DBZ_QUOT;
                            dbz_o  <= 1'b1;
                            done_o <= 1'b1;
                        end else begin
                            state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    h   <= h_nxt;
                    l   <= l_nxt;
                    cnt <= cnt + 4'd1;
                    if (cnt == 4'(ITER - 1)) begin
                        state  <= S_DONE;
                        hi_o   <= h_nxt;
                        lo_o   <= l_nxt;
                        dbz_o  <= 1'b0;
                        done_o <= 1'b1;
                    end
                end
                S_DONE: begin
                    state  <= S_IDLE;
                    busy_o <= 1'b0;
                end
                default: begin
                    state  <= S_IDLE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_seq_ctrl.sv
// tb/tb_mdu_seq_ctrl.sv - directed self-checking bench for mdu_seq_ctrl
module tb_mdu_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        op;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic [15:0] hi;
    logic [15:0] lo;
    logic        dbz;

    int checks   = 0;
    int failures = 0;

    mdu_seq_ctrl dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .start_i (start),
        .op_i    (op),
        .a_i     (a),
        .b_i     (b),
        .busy_o  (busy),
        .done_o  (done),
        .hi_o    (hi),
        .lo_o    (lo),
        .dbz_o   (dbz)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout observed=hang expected=finish");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one request in "cycle 0" and wait (bounded) for done_o; checks latency and results.
    task automatic run_op(input string tag, input logic o, input logic [15:0] av,
                          input logic [15:0] bv, input int exp_lat,
                          input logic [15:0] exp_hi, input logic [15:0] exp_lo,
                          input logic exp_dbz);
        int lat;
        start = 1'b1; op = o; a = av; b = bv;
        tick();
        start = 1'b0;
        lat = 1;
        while (!done && lat < 40) begin
            tick();
            lat++;
        end
        check({tag, "_latency"}, lat, exp_lat);
        check({tag, "_hi"}, {16'd0, hi}, {16'd0, exp_hi});
        check({tag, "_lo"}, {16'd0, lo}, {16'd0, exp_lo});
        check({tag, "_dbz"}, {31'd0, dbz}, {31'd0, exp_dbz});
        check({tag, "_busy_in_done"}, {31'd0, busy}, 32'd1);
        tick();
        check({tag, "_done_clears"}, {31'd0, done}, 32'd0);
        check({tag, "_busy_clears"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int seen;
        rst = 1'b1; start = 1'b0; op = 1'b0; a = 16'd0; b = 16'd0;
        tick();
        tick();
        rst = 1'b0;
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_hi", {16'd0, hi}, 32'd0);
        check("reset_lo", {16'd0, lo}, 32'd0);
        check("reset_dbz", {31'd0, dbz}, 32'd0);

        // MULU 3*5 with cycle-exact busy/done tracking
        start = 1'b1; op = 1'b0; a = 16'd3; b = 16'd5;
        tick();
        start = 1'b0;
        seen = 0;
        for (int cyc = 1; cyc <= 16; cyc++) begin
            if (done) seen++;
            if (!busy) seen++;
            tick();
        end
        check("mul3x5_no_early_done", seen, 0);
        check("mul3x5_done_c17", {31'd0, done}, 32'd1);
        check("mul3x5_hi", {16'd0, hi}, 32'h0000);
        check("mul3x5_lo", {16'd0, lo}, 32'h000F);
        check("mul3x5_dbz", {31'd0, dbz}, 32'd0);
        tick();
        check("mul3x5_idle_c18", {31'd0, busy}, 32'd0);

        run_op("mul_ffff", 1'b0, 16'hFFFF, 16'hFFFF, 17, 16'hFFFE, 16'h0001, 1'b0);
        run_op("div_100_7", 1'b1, 16'd100, 16'd7, 17, 16'd2, 16'd14, 1'b0);
        run_op("div_8000_ffff", 1'b1, 16'h8000, 16'hFFFF, 17, 16'h8000, 16'h0000, 1'b0);
        run_op("div_ffff_1", 1'b1, 16'hFFFF, 16'h0001, 17, 16'h0000, 16'hFFFF, 1'b0);
        run_op("div_by_zero", 1'b1, 16'h1234, 16'h0000, 1, 16'h1234, 16'hFFFF, 1'b1);
        run_op("mul_2x2", 1'b0, 16'd2, 16'd2, 17, 16'h0000, 16'h0004, 1'b0);

        // Starts during RUN (cycle 5) and DONE (cycle 17) must be ignored
        start = 1'b1; op = 1'b0; a = 16'd3; b = 16'd5;
        tick();
        start = 1'b0;
        seen = 0;
        for (int cyc = 1; cyc <= 16; cyc++) begin
            if (cyc == 5) begin
                start = 1'b1; op = 1'b0; a = 16'd7; b = 16'd9;
            end else begin
                start = 1'b0;
            end
            if (done) seen++;
            if (!busy) seen++;
            tick();
        end
        check("ignore_run_busy_done", seen, 0);
        check("ignore_done_c17", {31'd0, done}, 32'd1);
        check("ignore_lo", {16'd0, lo}, 32'd15);
        check("ignore_hi", {16'd0, hi}, 32'd0);
        start = 1'b1; op = 1'b1; a = 16'd9; b = 16'd0;
        tick();
        start = 1'b0;
        check("ignore_c18_busy", {31'd0, busy}, 32'd0);
        check("ignore_c18_done", {31'd0, done}, 32'd0);
        check("ignore_c18_lo", {16'd0, lo}, 32'd15);
        tick();
        check("ignore_c19_done", {31'd0, done}, 32'd0);

        // Reset in cycle 8 of a DIVU aborts it
        start = 1'b1; op = 1'b1; a = 16'd1000; b = 16'd3;
        tick();
        start = 1'b0;
        for (int cyc = 1; cyc < 8; cyc++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_hi", {16'd0, hi}, 32'd0);
        check("abort_lo", {16'd0, lo}, 32'd0);
        check("abort_dbz", {31'd0, dbz}, 32'd0);
        seen = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            if (done || busy) seen++;
            tick();
        end
        check("abort_quiet", seen, 0);
        run_op("after_abort", 1'b1, 16'd1000, 16'd3, 17, 16'd1, 16'd333, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
